fetch_queue: RTL and testbench

Instruction prefetch queue sitting between the instruction memory and the IF/ID pipeline register. It owns the fetch PC, issues sequential fetch requests to a synchronous (1-cycle) instruction memory, and buffers returned instructions tagged with their PC+4. It also absorbs decode-side stalls and handles branch/jump redirects by flushing buffered and in-flight instructions.

---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential requests to a
// 1-cycle instruction memory and buffers {instr, pc+4} entries for decode.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Redirect,
   input  logic [31:0]              RedirectPC,
   input  logic                     Stall,
   output logic                     IMemReq,
   output logic [31:0]              IMemAddr,
   input  logic [31:0]              IMemData,
   output logic                     Valid,
   output logic [31:0]              InstrOut,
   output logic [31:0]              PCPlus4Out,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   r_fetch_pc;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic [31:0]   r_instr_mem [DEPTH];
   logic [31:0]   r_pc4_mem   [DEPTH];

   logic [CW-1:0] w_occupancy;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;

   // Stored entries plus the outstanding request reserve slots, so a return always fits.
   assign w_occupancy = r_count + CW'(r_inflight);
   assign w_issue     = Rst && !Redirect && (w_occupancy < CW'(DEPTH));
   assign w_push      = r_inflight && !Redirect;
   assign w_pop       = Valid && !Stall && !Redirect;

   assign IMemReq    = w_issue;
   assign IMemAddr   = r_fetch_pc;
   assign Valid      = (r_count != '0);
   assign InstrOut   = Valid ? r_instr_mem[r_head] : 32'h0;
   assign PCPlus4Out = Valid ? r_pc4_mem[r_head]   : 32'h0;
   assign Count      = r_count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_fetch_pc    <= RESET_PC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (Redirect) begin
         r_fetch_pc <= RedirectPC;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_inflight_pc <= r_fetch_pc;
         end
         r_inflight <= w_issue;
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: entry storage has no reset; Count gates every read, so stale contents are never visible.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_instr_mem[r_tail] <= IMemData;
         r_pc4_mem[r_tail]   <= r_inflight_pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model returns data = address, and a
// scoreboard of expected {instr, pc+4} entries is checked against the queue head.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        valid;
   logic [31:0] instr_out;
   logic [31:0] pc_plus4_out;
   logic [2:0]  count;

   int          n_checks = 0;
   int          n_errors = 0;

   entry_t      sb_q [$];
   logic        m_inflight;
   logic [31:0] m_pc;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .Clk        (clk),
      .Rst        (rst),
      .Redirect   (redirect),
      .RedirectPC (redirect_pc),
      .Stall      (stall),
      .IMemReq    (imem_req),
      .IMemAddr   (imem_addr),
      .IMemData   (imem_data),
      .Valid      (valid),
      .InstrOut   (instr_out),
      .PCPlus4Out (pc_plus4_out),
      .Count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_inflight = 1'b0;
      m_pc       = RESET_PC;
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model, model the memory return.
   task automatic cycle();
      int          exp_cnt;
      logic        exp_req;
      logic        req_s;
      logic [31:0] addr_s;
      #3;
      exp_cnt = sb_q.size() - int'(m_inflight);
      exp_req = !redirect && (sb_q.size() < DEPTH);
      chk("IMemReq",  32'(imem_req), 32'(exp_req));
      chk("IMemAddr", imem_addr, m_pc);
      chk("Valid",    32'(valid), 32'(exp_cnt != 0));
      chk("Count",    32'(count), 32'(exp_cnt));
      if (exp_cnt > 0) begin
         chk("InstrOut",   instr_out,    sb_q[0].instr);
         chk("PCPlus4Out", pc_plus4_out, sb_q[0].pc4);
      end else begin
         chk("InstrOut_idle",   instr_out,    32'h0);
         chk("PCPlus4Out_idle", pc_plus4_out, 32'h0);
      end
      req_s  = imem_req;
      addr_s = imem_addr;
      if (redirect) begin
         sb_q.delete();
         m_inflight = 1'b0;
         m_pc       = redirect_pc;
      end else begin
         if (exp_cnt > 0 && !stall) void'(sb_q.pop_front());
         if (exp_req) begin
            sb_q.push_back('{m_pc, m_pc + 32'd4});
            m_pc       = m_pc + 32'd4;
            m_inflight = 1'b1;
         end else begin
            m_inflight = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      imem_data = req_s ? addr_s : 32'hDEAD_BEEF;
   endtask

   initial begin
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b1;
      imem_data   = 32'h0;
      model_reset();

      // Reset state
      #2;
      chk("rst_valid",    32'(valid),    32'h0);
      chk("rst_count",    32'(count),    32'h0);
      chk("rst_req",      32'(imem_req), 32'h0);
      chk("rst_addr",     imem_addr,     RESET_PC);
      chk("rst_instr",    instr_out,     32'h0);
      chk("rst_pcplus4",  pc_plus4_out,  32'h0);

      // Fill under stall
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) cycle();
      chk("fill_count",   32'(count),    32'd4);
      chk("fill_req",     32'(imem_req), 32'h0);
      chk("fill_instr",   instr_out,     32'h0);
      chk("fill_pcplus4", pc_plus4_out,  32'h4);

      // Redirect with three entries and one request outstanding
      rst = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      repeat (4) cycle();
      chk("pre_redir_count", 32'(count), 32'd3);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      cycle();
      redirect = 1'b0;
      stall    = 1'b0;
      chk("redir_count", 32'(count), 32'h0);
      chk("redir_valid", 32'(valid), 32'h0);
      cycle();
      cycle();
      chk("redir_instr",   instr_out,    32'h100);
      chk("redir_pcplus4", pc_plus4_out, 32'h104);
      repeat (6) cycle();

      // Redirect wins over a pop of a valid head
      chk("prio_valid", 32'(valid), 32'h1);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      cycle();
      redirect = 1'b0;
      repeat (5) cycle();

      // Async reset mid-stream, then stream from reset
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(valid),    32'h0);
      chk("arst_count", 32'(count),    32'h0);
      chk("arst_req",   32'(imem_req), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      repeat (12) cycle();

      // Random stall pattern
      for (int i = 0; i < 30; i++) begin
         stall = ($urandom_range(0, 2) == 0);
         cycle();
      end
      stall = 1'b0;

      // PC wrap
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      cycle();
      redirect = 1'b0;
      cycle();
      cycle();
      chk("wrap_pcplus4_0", pc_plus4_out, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_pcplus4_1", pc_plus4_out, 32'h0000_0000);
      cycle();
      chk("wrap_instr_2",   instr_out,    32'h0000_0000);
      chk("wrap_pcplus4_2", pc_plus4_out, 32'h0000_0004);
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
